// File: rtl/serv_bus_arbiter_pkg.sv
// Shared definitions for the SERV ibus/dbus Wishbone arbiter: state encodings
// and the request bundle that the grant mux selects between.
package serv_bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_IBUS = 2'd1;
  localparam logic [1:0] ARB_DBUS = 2'd2;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
  } wb_req_t;

  function automatic logic arb_granted(input logic [1:0] st);
    return st != ARB_IDLE;
  endfunction

endpackage

// File: rtl/serv_bus_watchdog.sv
// Transaction watchdog: counts granted cycles without ack and flags the cycle
// in which the counter would reach all-ones (the 2**W-1'th waiting cycle).
module serv_bus_watchdog #(
  parameter int W = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);

  localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      cnt <= '0;
    else if (i_clr) cnt <= '0;
    else if (i_inc) cnt <= cnt + 1'b1;
  end

  assign o_timeout = i_inc && (cnt == LAST);

endmodule

// File: rtl/serv_bus_arbiter.sv
// Shares one Wishbone master port between SERV ibus and dbus: registered grant,
// fixed dbus priority, idle turnaround. Watchdog enabled by SERV_BUS_TIMEOUT_EN.
module serv_bus_arbiter
  import serv_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_bus_err
);

  logic [1:0] state, state_nxt;
  wb_req_t    ireq, dreq, greq;
  logic       timeout, done;

  assign ireq = '{adr: i_ibus_adr, dat: 32'h0, sel: 4'h0, we: 1'b0, cyc: i_ibus_cyc};
  assign dreq = '{adr: i_dbus_adr, dat: i_dbus_dat, sel: i_dbus_sel, we: i_dbus_we, cyc: i_dbus_cyc};

  // Idle still presents the fetch address so the bus is not left floating.
  always_comb begin
    greq     = '0;
    greq.adr = i_ibus_adr;
    case (state)
      ARB_IBUS: greq = ireq;
      ARB_DBUS: greq = dreq;
      default:  ;
    endcase
  end

`ifdef SERV_BUS_TIMEOUT_EN
  serv_bus_watchdog #(.W(TIMEOUT_W)) u_wdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (!arb_granted(state)),
    .i_inc     (greq.cyc && !i_wb_ack),
    .o_timeout (timeout)
  );
`else
  logic wdog_unused;
  assign wdog_unused = (TIMEOUT_W > 0);
  assign timeout     = 1'b0;
`endif

  assign done = i_wb_ack || timeout;

  assign o_wb_adr   = greq.adr;
  assign o_wb_dat   = greq.dat;
  assign o_wb_sel   = greq.sel;
  assign o_wb_we    = greq.we;
  assign o_wb_cyc   = greq.cyc && !timeout;
  assign o_ibus_ack = (state == ARB_IBUS) && i_ibus_cyc && done;
  assign o_dbus_ack = (state == ARB_DBUS) && i_dbus_cyc && done;
  // A timed-out requester sees a clean zero rather than whatever the slave drives.
  assign o_ibus_rdt = timeout ? 32'h0 : i_wb_rdt;
  assign o_dbus_rdt = timeout ? 32'h0 : i_wb_rdt;
  assign o_bus_err  = timeout;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (i_dbus_cyc)      state_nxt = ARB_DBUS;
        else if (i_ibus_cyc) state_nxt = ARB_IBUS;
      end
      ARB_IBUS, ARB_DBUS: begin
        if (!greq.cyc || done) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Bench for serv_bus_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level ownership model of the shared bus.
module tb_serv_bus_arbiter;

  localparam int TW    = 4;
  localparam int LIMIT = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ibus_adr, i_dbus_adr, i_dbus_dat, i_wb_rdt;
  logic        i_ibus_cyc, i_dbus_cyc, i_dbus_we, i_wb_ack;
  logic [3:0]  i_dbus_sel;
  logic [31:0] o_ibus_rdt, o_dbus_rdt, o_wb_adr, o_wb_dat;
  logic        o_ibus_ack, o_dbus_ack, o_wb_we, o_wb_cyc, o_bus_err;
  logic [3:0]  o_wb_sel;

  always #5 clk = ~clk;

  serv_bus_arbiter #(.TIMEOUT_W(TW)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
    .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
    .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
    .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .o_bus_err(o_bus_err)
  );

  int   n_tests = 0, n_fail = 0;
  int   owner = 0;   // 0 = bus free, 1 = ibus owns it, 2 = dbus owns it
  int   waited = 0;  // owned cycles so far that ended without ack
  logic iack_seen = 1'b0, dack_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: called at posedge+1, checks mid-cycle, returns at next posedge+1.
  task automatic step();
    logic cyc_exp, to, eia, eda;
    int   nxt;
    #3;
    cyc_exp = (owner == 1) ? i_ibus_cyc : (owner == 2) ? i_dbus_cyc : 1'b0;
`ifdef SERV_BUS_TIMEOUT_EN
    to = cyc_exp && !i_wb_ack && (waited == LIMIT - 1);
`else
    to = 1'b0;
`endif
    eia = (owner == 1) && cyc_exp && (i_wb_ack || to);
    eda = (owner == 2) && cyc_exp && (i_wb_ack || to);
    chk("wb_cyc",   o_wb_cyc,   cyc_exp && !to);
    chk("wb_adr",   o_wb_adr,   (owner == 2) ? i_dbus_adr : i_ibus_adr);
    chk("wb_dat",   o_wb_dat,   (owner == 2) ? i_dbus_dat : 32'h0);
    chk("wb_sel",   o_wb_sel,   (owner == 2) ? i_dbus_sel : 4'h0);
    chk("wb_we",    o_wb_we,    (owner == 2) && i_dbus_we);
    chk("ibus_ack", o_ibus_ack, eia);
    chk("dbus_ack", o_dbus_ack, eda);
    chk("ibus_rdt", o_ibus_rdt, to ? 32'h0 : i_wb_rdt);
    chk("dbus_rdt", o_dbus_rdt, to ? 32'h0 : i_wb_rdt);
    chk("bus_err",  o_bus_err,  to);
    iack_seen = eia;
    dack_seen = eda;
    if (owner == 0) nxt = i_dbus_cyc ? 2 : (i_ibus_cyc ? 1 : 0);
    else            nxt = (!cyc_exp || i_wb_ack || to) ? 0 : owner;
    @(posedge clk);
    if (nxt != owner) waited = 0;
    else if (owner != 0) waited++;
    owner = nxt;
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    i_ibus_adr = 32'h0; i_ibus_cyc = 1'b0;
    i_dbus_adr = 32'h0; i_dbus_dat = 32'h0; i_dbus_sel = 4'h0;
    i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
    i_wb_rdt = 32'h0; i_wb_ack = 1'b0;

    // Reset state, with requests and a stray ack pending
    #2;
    i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1; i_wb_ack = 1'b1; i_dbus_we = 1'b1;
    #1;
    chk("rst_cyc",  o_wb_cyc,   1'b0);
    chk("rst_iack", o_ibus_ack, 1'b0);
    chk("rst_dack", o_dbus_ack, 1'b0);
    chk("rst_err",  o_bus_err,  1'b0);
    chk("rst_we",   o_wb_we,    1'b0);
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0; i_wb_ack = 1'b0; i_dbus_we = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b0;

    // Fetch with slave ack two cycles after cyc rises
    i_ibus_adr = 32'h100; i_ibus_cyc = 1'b1;
    step(); step(); step();
    i_wb_ack = 1'b1; i_wb_rdt = 32'hDEADBEEF;
    step();
    chk("fetch_acked", iack_seen, 1'b1);
    i_ibus_cyc = 1'b0; i_wb_ack = 1'b0;
    step();

    // Simultaneous requests: dbus write wins, idle gap, then ibus
    i_ibus_adr = 32'h104; i_ibus_cyc = 1'b1;
    i_dbus_adr = 32'h2000; i_dbus_dat = 32'h55; i_dbus_sel = 4'hF;
    i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    step(); step();
    i_wb_ack = 1'b1;
    step();
    chk("write_acked", dack_seen, 1'b1);
    i_dbus_cyc = 1'b0; i_dbus_we = 1'b0; i_wb_ack = 1'b0;
    step(); step();
    i_wb_ack = 1'b1;
    step();
    i_ibus_cyc = 1'b0;

    // Zero-wait dbus reads back to back, plus ack while idle
    i_dbus_adr = 32'h3000; i_dbus_cyc = 1'b1; i_wb_ack = 1'b1;
    repeat (6) step();
    i_dbus_cyc = 1'b0;
    repeat (3) step();
    i_wb_ack = 1'b0;

    // Reset in the middle of a dbus transaction, ibus pending
    i_dbus_cyc = 1'b1; i_ibus_cyc = 1'b1; i_ibus_adr = 32'h200;
    step(); step();
    #3; i_rst = 1'b1; #1;
    chk("midrst_cyc",  o_wb_cyc,   1'b0);
    chk("midrst_dack", o_dbus_ack, 1'b0);
    chk("midrst_iack", o_ibus_ack, 1'b0);
    owner = 0; waited = 0;
    @(posedge clk); #1;
    i_rst = 1'b0; i_dbus_cyc = 1'b0;
    step(); step();
    i_wb_ack = 1'b1;
    step();
    chk("post_rst_fetch", iack_seen, 1'b1);
    i_ibus_cyc = 1'b0; i_wb_ack = 1'b0;
    step();

`ifdef SERV_BUS_TIMEOUT_EN
    // Slave never acks: watchdog terminates the fetch
    i_ibus_cyc = 1'b1; i_wb_rdt = 32'hA5A5A5A5;
    repeat (LIMIT + 2) begin
      step();
      if (iack_seen) i_ibus_cyc = 1'b0;
    end
    i_ibus_cyc = 1'b0;
    step();
`endif

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      if (iack_seen || (i_ibus_cyc && $urandom_range(0, 31) == 0)) i_ibus_cyc = 1'b0;
      else if (!i_ibus_cyc) begin
        i_ibus_adr = $urandom;
        i_ibus_cyc = 1'($urandom_range(0, 1));
      end
      if (dack_seen || (i_dbus_cyc && $urandom_range(0, 31) == 0)) i_dbus_cyc = 1'b0;
      else if (!i_dbus_cyc) begin
        i_dbus_adr = $urandom;
        i_dbus_dat = $urandom;
        i_dbus_sel = 4'($urandom);
        i_dbus_we  = 1'($urandom_range(0, 1));
        i_dbus_cyc = ($urandom_range(0, 2) == 0);
      end
      i_wb_ack = ($urandom_range(0, 99) < 40);
      i_wb_rdt = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
